// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// No logic; compile-time values only.
// No flow control involved.
package seq_det_pkg;

  localparam logic OVERLAP_ON  = 1'b1;
  localparam logic OVERLAP_OFF = 1'b0;

  // Default 4-sample "1 x x 1" configuration.
  localparam logic [3:0] DEFAULT_PATTERN   = 4'b1001;
  localparam logic [3:0] DEFAULT_CARE_MASK = 4'b1001;

  // Bits needed to hold a fill level of 0..len-1.
  function automatic int fill_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Stream, configuration and status bundle of the pattern detector.
// No logic; wiring only.
// No flow control: enable qualifies each sample, nothing pushes back.
interface seq_pattern_detector_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
);
  import seq_det_pkg::*;

  logic             w;
  logic             enable;
  logic [LEN-1:0]   pattern;
  logic [LEN-1:0]   care_mask;
  logic             overlap;
  logic             cnt_clear;
  logic             z;
  logic [CNT_W-1:0] match_count;

  modport master (
    output w, enable, pattern, care_mask, overlap, cnt_clear,
    input  z, match_count
  );

  modport slave (
    input  w, enable, pattern, care_mask, overlap, cnt_clear,
    output z, match_count
  );

endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Count updates one cycle after inc/clr.
// No backpressure; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins; otherwise count up until all ones, then hold.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: z flags the last LEN samples matching pattern under care_mask.
// z is combinational (same cycle as the sample); SEQ_DET_MATCH_REG_EN registers it (+1 cycle).
// No backpressure; enable=0 stalls the history and count, never drops a sample.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input logic                    clock,
  input logic                    Reset,
  seq_pattern_detector_if.slave  bus
);

  localparam int             FW        = fill_width(LEN);
  localparam logic [FW-1:0]  FILL_FULL = FW'(LEN - 1);

  logic [LEN-2:0]   hist;
  logic [FW-1:0]    fill;
  logic [LEN-1:0]   window;
  logic             match;
  logic [CNT_W-1:0] count;

  // Oldest sample sits in the MSB, the live input in bit 0.
  assign window = {hist, bus.w};

  // Match needs a full history even when the upper mask bits are don't-care.
  always_comb begin
    match = 1'b0;
    if (bus.enable && (fill == FILL_FULL)) begin
      match = (((window ^ bus.pattern) & bus.care_mask) == '0);
    end
  end

  // History shift and fill tracking; a non-overlapping match restarts collection.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      hist <= '0;
      fill <= '0;
    end else if (bus.enable) begin
      if (match && (bus.overlap == OVERLAP_OFF)) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= window[LEN-2:0];
        if (fill != FILL_FULL) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clock (clock),
    .Reset (Reset),
    .inc   (match),
    .clr   (bus.cnt_clear),
    .count (count)
  );

  assign bus.match_count = count;

`ifdef SEQ_DET_MATCH_REG_EN
  logic z_q;

  // One-cycle pulse after the matching sample; not gated by the next cycle's enable.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      z_q <= 1'b0;
    end else begin
      z_q <= match;
    end
  end

  assign bus.z = z_q;
`else
  assign bus.z = match;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
`timescale 1ns/1ps
module tb_seq_pattern_detector;
  import seq_det_pkg::*;

  localparam int LEN = 4;

  logic clock = 1'b0;
  logic Reset = 1'b0;
  always #5 clock = ~clock;

  seq_pattern_detector_if #(.LEN(LEN), .CNT_W(8)) bus ();
  seq_pattern_detector_if #(.LEN(LEN), .CNT_W(2)) bus_sat ();

  // Second instance (narrow counter) sees the same stimulus.
  assign bus_sat.w         = bus.w;
  assign bus_sat.enable    = bus.enable;
  assign bus_sat.pattern   = bus.pattern;
  assign bus_sat.care_mask = bus.care_mask;
  assign bus_sat.overlap   = bus.overlap;
  assign bus_sat.cnt_clear = bus.cnt_clear;

  seq_pattern_detector #(.LEN(LEN), .CNT_W(8)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  seq_pattern_detector #(.LEN(LEN), .CNT_W(2)) dut_sat (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus_sat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [LEN-2:0] m_hist;
  int             m_fill;
  int             m_cnt8;
  int             m_cnt2;
  bit             exp_z_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match(input bit wv, input bit en,
                                     input logic [LEN-1:0] pat,
                                     input logic [LEN-1:0] mask);
    logic [LEN-1:0] win;
    win = {m_hist, wv};
    if (!en || (m_fill != LEN - 1)) return 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (mask[i] && (win[i] != pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic set_cfg(input logic [LEN-1:0] pat, input logic [LEN-1:0] mask,
                         input logic ov);
    bus.pattern   = pat;
    bus.care_mask = mask;
    bus.overlap   = ov;
  endtask

  // One clock of stimulus: drive at negedge, score z and the counters.
  task automatic step(input bit wv, input bit en, input bit clr);
    bit             m;
    logic [LEN-1:0] win;
    @(negedge clock);
    bus.w         = wv;
    bus.enable    = en;
    bus.cnt_clear = clr;
    m = model_match(wv, en, bus.pattern, bus.care_mask);
    exp_z_q.push_back(m);
`ifndef SEQ_DET_MATCH_REG_EN
    #4;
    check("z", int'(bus.z), int'(exp_z_q.pop_front()));
`endif
    @(posedge clock);
    #1;
    win = {m_hist, wv};
    if (en) begin
      if (m && !bus.overlap) begin
        m_hist = '0;
        m_fill = 0;
      end else begin
        m_hist = win[LEN-2:0];
        if (m_fill < LEN - 1) m_fill++;
      end
    end
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (m) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
`ifdef SEQ_DET_MATCH_REG_EN
    check("z_reg", int'(bus.z), int'(exp_z_q.pop_front()));
`endif
    check("match_count", int'(bus.match_count), m_cnt8);
    check("match_count_sat", int'(bus_sat.match_count), m_cnt2);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.enable    = 1'b0;
    bus.cnt_clear = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check("rst_z", int'(bus.z), 0);
    check("rst_count", int'(bus.match_count), 0);
    check("rst_count_sat", int'(bus_sat.match_count), 0);
    m_hist = '0;
    m_fill = 0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    exp_z_q.delete();
    @(negedge clock);
    Reset = 1'b1;
  endtask

  task automatic run_stream(input logic [6:0] bits);
    for (int i = 6; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
  endtask

  initial begin
    bus.w = 1'b0; bus.enable = 1'b0; bus.cnt_clear = 1'b0;
    set_cfg(DEFAULT_PATTERN, DEFAULT_CARE_MASK, OVERLAP_ON);
    #3;
    check("por_z", int'(bus.z), 0);
    check("por_count", int'(bus.match_count), 0);
    m_hist = '0; m_fill = 0; m_cnt8 = 0; m_cnt2 = 0;
    @(negedge clock);
    Reset = 1'b1;

    // 1xx1 overlapping: matches on samples 4 and 7
    run_stream(7'b1011001);
    check("ovl_total", int'(bus.match_count), 2);

    // Same stream non-overlapping: only sample 4
    do_reset();
    set_cfg(DEFAULT_PATTERN, DEFAULT_CARE_MASK, OVERLAP_OFF);
    run_stream(7'b1011001);
    check("novl_total", int'(bus.match_count), 1);

    // Reset mid-sequence discards the partial 1,0,1
    do_reset();
    set_cfg(4'b1011, 4'b1111, OVERLAP_ON);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    check("after_rst_nomatch", int'(bus.match_count), 0);
    step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    check("full_1011", int'(bus.match_count), 1);

    // Stall: enable=0 with w toggling must not disturb history
    do_reset();
    set_cfg(DEFAULT_PATTERN, DEFAULT_CARE_MASK, OVERLAP_ON);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    check("stall_count", int'(bus.match_count), 0);
    step(1'b1, 1'b1, 1'b0);
    check("after_stall", int'(bus.match_count), 1);

    // Mask all zeros: saturate the narrow counter, then clear beats a match
    do_reset();
    set_cfg(4'b0000, 4'b0000, OVERLAP_ON);
    for (int i = 0; i < 8; i++) step(i[0], 1'b1, 1'b0);
    check("sat_wide", int'(bus.match_count), 5);
    check("sat_narrow", int'(bus_sat.match_count), 3);
    step(1'b1, 1'b1, 1'b1);
    check("clr_wide", int'(bus.match_count), 0);
    check("clr_narrow", int'(bus_sat.match_count), 0);
    step(1'b0, 1'b1, 1'b0);
    check("clr_keeps_fill", int'(bus.match_count), 1);

    // Mask zero non-overlapping: one match every LEN samples
    do_reset();
    set_cfg(4'b0000, 4'b0000, OVERLAP_OFF);
    for (int i = 0; i < 3 * LEN; i++) step(1'b1, 1'b1, 1'b0);
    check("novl_mask0", int'(bus.match_count), 3);

    // Random traffic with live configuration changes
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_cfg(LEN'($urandom), LEN'($urandom), 1'($urandom));
      step(1'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 30) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
